dsp48a1_mac_seq: RTL and testbench
==================================

Name: dsp48a1_mac_seq

Overview:
- Operand sequencer and result collector that drives one DSP48A1 slice, configured as a multiply-accumulate engine.
- Accepts a stream of signed 18-bit (a,b) pairs with valid/ready. Pairs are grouped into vectors by in_last.
- Generates OPMODE per pair and tracks elements through the slice pipeline.
- Captures each finished dot product from P into a result FIFO with valid/ready output.
- Targets a slice built with A0REG=A1REG=B0REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT="DIRECT", RSTTYPE="SYNC".

Parameters:
- DSP_LAT, 4, cycles from operand presented on dsp_a/dsp_b to its product contribution visible on dsp_p.
- OPMODE_DLY, 2, cycles OPMODE is delayed behind operands so it sits in the slice OPMODE register while M holds that product.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  clock; shared with the DSP48A1.
- RST  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  18  signed multiplicand.
- in_b  in  18  signed multiplier.
- in_last  in  1  pair is the final element of the current vector.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer takes result.
- out_data  out  48  signed dot product (FIFO head).
- out_count  out  16  number of elements in the vector at the FIFO head.
- dsp_a  out  18  to DSP48A1 A.
- dsp_b  out  18  to DSP48A1 B.
- dsp_opmode  out  8  to DSP48A1 OPMODE.
- dsp_ce  out  1  drives all slice CE inputs.
- dsp_rst  out  1  drives all slice RST inputs.
- dsp_p  in  48  from DSP48A1 P.

Behaviour:
- Reset (RST high at a CLK edge):
  - Clears the tag pipeline, opmode delay line, FIFO pointers, element counter and the first-of-vector flag (flag set to 1).
  - Outputs during reset: dsp_a=0, dsp_b=0, dsp_opmode=8'h08, dsp_ce=1, dsp_rst=1.
  - Status outputs: in_ready=0, out_valid=0, out_data=0, out_count=0.
  - In-flight elements are discarded; no partial result is ever pushed.
  - dsp_rst is a registered copy of RST, so it falls one cycle after RST falls.
  - in_ready is 0 during that cycle.
- Accept condition: accept = in_valid & in_ready. dsp_a/dsp_b are registered from in_a/in_b on accept; 0 otherwise.
- OPMODE encoding (pre-adder bypassed, post-adder add, CARRYIN 0):
  - First element of a vector: 8'h01 (X=M, Z=0).
  - Later elements: 8'h09 (X=M, Z=P).
  - Bubble (no accept): 8'h08 (X=0, Z=P, holds P).
- The chosen OPMODE passes through the OPMODE_DLY-stage delay line before reaching dsp_opmode. The delay line resets to 8'h08.
- First-of-vector flag: cleared on any accept without in_last; set on an accept with in_last.
- Length-1 vector (first and last element together): uses 8'h01.
- Element counter:
  - Increments on each accept.
  - Its value including the current element is latched into the tag on an in_last accept.
  - Resets to 0 after an in_last accept.
  - Saturates at 16'hFFFF.
- Tag pipeline: DSP_LAT stages carrying {valid, last, count}. Advances every cycle; dsp_ce is held at 1 outside reset.
- Result capture: when the output stage holds valid&last, dsp_p and count are pushed into the FIFO in that same cycle.
- Credit rule: in_ready = (fifo_count + lasts_in_flight) < FIFO_DEPTH, where lasts_in_flight counts tag stages holding valid&last. This guarantees a push never meets a full FIFO.
- Pair with in_last=0 while credits are exhausted: still blocked, since in_ready is a single condition.
- FIFO ordering: first-word-fall-through; out_valid = non-empty.
- Same-cycle events: pop on out_valid & out_ready. Simultaneous push and pop keeps the count unchanged. A push into an empty FIFO is visible on out_valid the next cycle.
- Arithmetic: the 36-bit signed product is sign-extended to 48 bits inside the slice. Accumulation wraps modulo 2^48 with no overflow flag.
- Latency: the in_last accept at cycle t gives out_valid at cycle t+DSP_LAT+1 when the FIFO was empty.
- Back-to-back vectors with no bubble are supported at one pair per cycle.

Test Plan:
- Reset: RST held 3 cycles then released -> dsp_rst=1 through one cycle after release; in_ready=0 until then; out_valid=0; dsp_opmode=8'h08.
- Single vector: (2,3),(4,5),(-1,7) on consecutive cycles, last on third -> one result out_data=19, out_count=3, at 5 cycles after the third accept.
- Bubbles inside a vector: (100,100), 3 idle cycles, (-50,2) last -> out_data=9900, out_count=2; P held across the bubbles.
- Back-to-back length-1 vectors: (1,1),(2,2),(3,3),(4,4),(5,5), each last, with out_ready=0 -> in_ready drops after the fourth accept. The FIFO holds 1,4,9,16. Raising out_ready then delivers those in order, and the fifth accept completes with result 25.
- Extremes: (-131072,-131072) x4 in one vector -> out_data=68719476736 (4*2^34), no wrap.
- Reset mid-vector: two pairs accepted, RST pulsed -> no result emitted. The next vector (7,6) last -> out_data=42, out_count=1.

Source files
------------

// File: rtl/dsp48a1_mac_seq.sv
// Operand sequencer and dot-product collector for one DSP48A1 slice run as a MAC; result valid DSP_LAT+1 cycles after the last accept.
// Backpressure: in_ready stays low unless the result FIFO has room reserved for every vector end still inside the slice.
module dsp48a1_mac_seq #(
  parameter int DSP_LAT    = 4,
  parameter int OPMODE_DLY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [17:0] in_a,
  input  logic signed [17:0] in_b,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [47:0] out_data,
  output logic [15:0]        out_count,
  output logic signed [17:0] dsp_a,
  output logic signed [17:0] dsp_b,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_ce,
  output logic               dsp_rst,
  input  logic signed [47:0] dsp_p
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] OP_FIRST = 8'h01;
  localparam logic [7:0] OP_ACCUM = 8'h09;
  localparam logic [7:0] OP_HOLD  = 8'h08;

  typedef struct packed {
    logic        vld;
    logic        last;
    logic [15:0] cnt;
  } tag_t;

  logic signed [17:0] r_dsp_a;
  logic signed [17:0] r_dsp_b;
  logic               r_dsp_rst;
  logic               r_first;
  logic [15:0]        r_elem_cnt;
  logic [7:0]         r_op  [0:OPMODE_DLY];
  // Stage 0 rides alongside dsp_a/dsp_b; stage DSP_LAT lines up with the finished P.
  tag_t               r_tag [0:DSP_LAT];

  logic signed [47:0] r_mem_data [FIFO_DEPTH];
  logic [15:0]        r_mem_cnt  [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_fifo_cnt;

  logic        w_acc;
  logic        w_push;
  logic        w_pop;
  logic        w_credit_ok;
  logic [7:0]  w_lasts;
  logic [7:0]  w_op_sel;
  logic [15:0] w_cnt_inc;
  tag_t        w_tag_in;

  always_comb begin
    w_lasts = 8'd0;
    for (int i = 0; i <= DSP_LAT; i++) begin
      if (r_tag[i].vld && r_tag[i].last) w_lasts = w_lasts + 8'd1;
    end
  end

  assign w_credit_ok = (32'(w_lasts) + 32'(r_fifo_cnt)) < 32'(FIFO_DEPTH);
  assign in_ready    = ~RST & ~r_dsp_rst & w_credit_ok;
  assign w_acc       = in_valid & in_ready;
  assign w_cnt_inc   = (r_elem_cnt == 16'hFFFF) ? 16'hFFFF : r_elem_cnt + 16'd1;
  assign w_op_sel    = !w_acc ? OP_HOLD : (r_first ? OP_FIRST : OP_ACCUM);

  always_comb begin
    w_tag_in      = '0;
    w_tag_in.vld  = w_acc;
    w_tag_in.last = w_acc & in_last;
    w_tag_in.cnt  = (w_acc & in_last) ? w_cnt_inc : 16'd0;
  end

  assign w_push = r_tag[DSP_LAT].vld & r_tag[DSP_LAT].last;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    r_dsp_rst <= RST;
    if (RST) begin
      r_dsp_a    <= '0;
      r_dsp_b    <= '0;
      r_first    <= 1'b1;
      r_elem_cnt <= '0;
      for (int i = 0; i <= OPMODE_DLY; i++) r_op[i] <= OP_HOLD;
      for (int i = 0; i <= DSP_LAT; i++) r_tag[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      r_dsp_a <= w_acc ? in_a : 18'sd0;
      r_dsp_b <= w_acc ? in_b : 18'sd0;
      if (w_acc) begin
        r_first    <= in_last;
        r_elem_cnt <= in_last ? 16'd0 : w_cnt_inc;
      end
      r_op[0] <= w_op_sel;
      for (int i = 1; i <= OPMODE_DLY; i++) r_op[i] <= r_op[i-1];
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= DSP_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_mem_data[r_wr_ptr] <= dsp_p;
      r_mem_cnt[r_wr_ptr]  <= r_tag[DSP_LAT].cnt;
    end
  end

  assign out_valid  = (r_fifo_cnt != '0);
  assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : 48'sd0;
  assign out_count  = out_valid ? r_mem_cnt[r_rd_ptr] : 16'd0;
  assign dsp_a      = r_dsp_a;
  assign dsp_b      = r_dsp_b;
  assign dsp_opmode = r_op[OPMODE_DLY];
  assign dsp_ce     = 1'b1;
  assign dsp_rst    = r_dsp_rst;

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Directed bench for dsp48a1_mac_seq driving a behavioural DSP48A1 slice
// (A0/A1, B0/B1, M, P and OPMODE registers, synchronous reset).
module tb_dsp48a1_mac_seq;

  logic               CLK;
  logic               RST;
  logic               in_valid;
  logic               in_ready;
  logic signed [17:0] in_a;
  logic signed [17:0] in_b;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [47:0] out_data;
  logic [15:0]        out_count;
  logic signed [17:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic               dsp_rst;
  logic signed [47:0] dsp_p;

  int n_assert = 0;
  int n_fail   = 0;

  dsp48a1_mac_seq #(.DSP_LAT(4), .OPMODE_DLY(2), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_rst(dsp_rst), .dsp_p(dsp_p)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Slice model: two input register stages, M register, OPMODE register, P register.
  logic signed [17:0] s_a0, s_a1, s_b0, s_b1;
  logic signed [35:0] s_m;
  logic [7:0]         s_op;
  logic signed [47:0] s_p;
  logic signed [47:0] s_x, s_z;

  always_comb begin
    s_x = (s_op[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'sd0;
    s_z = (s_op[3:2] == 2'b10) ? s_p : 48'sd0;
  end

  always @(posedge CLK) begin
    if (dsp_rst) begin
      s_a0 <= '0; s_a1 <= '0; s_b0 <= '0; s_b1 <= '0;
      s_m  <= '0; s_op <= '0; s_p  <= '0;
    end else if (dsp_ce) begin
      s_a0 <= dsp_a; s_a1 <= s_a0;
      s_b0 <= dsp_b; s_b1 <= s_b0;
      s_m  <= s_a1 * s_b1;
      s_op <= dsp_opmode;
      s_p  <= s_x + s_z;
    end
  end
  assign dsp_p = s_p;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present one pair, wait (bounded) for in_ready, let it be accepted on the next edge.
  task automatic send(input logic signed [17:0] a, input logic signed [17:0] b, input logic last);
    int guard;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick(1);
      guard++;
    end
    chk("send_ready", in_ready, 1);
    tick(1);
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;

    // Reset held three cycles
    tick(3);
    chk("rst_dsp_rst", dsp_rst, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_opmode", dsp_opmode, 8'h08);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_dsp_ce", dsp_ce, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    RST = 1'b0;
    #1;
    chk("rel_dsp_rst_hold", dsp_rst, 1);
    chk("rel_in_ready_low", in_ready, 0);
    tick(1);
    chk("rel_dsp_rst_fall", dsp_rst, 0);
    chk("rel_in_ready_up", in_ready, 1);
    chk("rel_opmode", dsp_opmode, 8'h08);

    // Single vector: 2*3 + 4*5 + (-1)*7 = 19
    send(18'sd2, 18'sd3, 1'b0);
    send(18'sd4, 18'sd5, 1'b0);
    send(-18'sd1, 18'sd7, 1'b1);
    tick(4);
    chk("vec1_not_yet", out_valid, 0);
    tick(1);
    chk("vec1_valid", out_valid, 1);
    chk("vec1_data", out_data, 19);
    chk("vec1_count", out_count, 3);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("vec1_popped", out_valid, 0);

    // Bubbles inside a vector: 100*100 - 50*2 = 9900
    send(18'sd100, 18'sd100, 1'b0);
    tick(3);
    send(-18'sd50, 18'sd2, 1'b1);
    chk("bub_p_first", dsp_p, 10000);
    tick(2);
    chk("bub_p_held", dsp_p, 10000);
    tick(2);
    chk("bub_p_final", dsp_p, 9900);
    chk("bub_not_yet", out_valid, 0);
    tick(1);
    chk("bub_valid", out_valid, 1);
    chk("bub_data", out_data, 9900);
    chk("bub_count", out_count, 2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("bub_popped", out_valid, 0);

    // Back-to-back length-1 vectors against a stalled consumer
    send(18'sd1, 18'sd1, 1'b1);
    send(18'sd2, 18'sd2, 1'b1);
    send(18'sd3, 18'sd3, 1'b1);
    send(18'sd4, 18'sd4, 1'b1);
    chk("b2b_credit_out", in_ready, 0);
    in_valid = 1'b1; in_a = 18'sd5; in_b = 18'sd5; in_last = 1'b1;
    tick(6);
    chk("b2b_still_blocked", in_ready, 0);
    chk("b2b_head_valid", out_valid, 1);
    chk("b2b_head0", out_data, 1);
    chk("b2b_head0_cnt", out_count, 1);
    out_ready = 1'b1;
    tick(1);
    chk("b2b_head1", out_data, 4);
    chk("b2b_ready_back", in_ready, 1);
    tick(1);
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    chk("b2b_head2", out_data, 9);
    tick(1);
    chk("b2b_head3", out_data, 16);
    tick(1);
    chk("b2b_drained", out_valid, 0);
    tick(2);
    chk("b2b_fifth_not_yet", out_valid, 0);
    tick(1);
    chk("b2b_fifth_valid", out_valid, 1);
    chk("b2b_fifth", out_data, 25);
    chk("b2b_fifth_cnt", out_count, 1);
    tick(1);
    out_ready = 1'b0;
    chk("b2b_empty", out_valid, 0);

    // Extremes: 4 * (-2^17)^2 = 2^36 = 68719476736
    send(-18'sd131072, -18'sd131072, 1'b0);
    send(-18'sd131072, -18'sd131072, 1'b0);
    send(-18'sd131072, -18'sd131072, 1'b0);
    send(-18'sd131072, -18'sd131072, 1'b1);
    tick(5);
    chk("ext_valid", out_valid, 1);
    chk("ext_data", out_data, 64'sd68719476736);
    chk("ext_count", out_count, 4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("ext_popped", out_valid, 0);

    // Reset in the middle of a vector discards the partial sum
    send(18'sd9, 18'sd9, 1'b0);
    send(18'sd8, 18'sd8, 1'b0);
    RST = 1'b1;
    tick(2);
    chk("mid_rst_ready", in_ready, 0);
    RST = 1'b0;
    tick(1);
    chk("mid_rst_dsp_rst_fall", dsp_rst, 0);
    tick(8);
    chk("mid_rst_no_result", out_valid, 0);
    send(18'sd7, 18'sd6, 1'b1);
    tick(4);
    chk("mid_rst_not_yet", out_valid, 0);
    tick(1);
    chk("mid_rst_valid", out_valid, 1);
    chk("mid_rst_data", out_data, 42);
    chk("mid_rst_count", out_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
